hazard_control_unit: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core (fetch, decoder, execution, memory, write_back).
- Detects load-use hazards, taken branches resolved in the memory stage, and data-memory wait states.
- Drives the PC-load, stage-register write-enable, bubble and flush controls.
- A small FSM with a watchdog counter tracks memory wait states and traps a hung data memory.

---
 rtl/hazard_control_unit_if.sv | 40 ++++
 rtl/hazard_control_unit.sv | 167 ++++++++++++++++
 tb/tb_hazard_control_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard control handshake bundle.
// master: pipeline side (drives hazard sources); slave: hazard_control_unit.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  mem_branch_taken;
    logic                  mem_access;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_bubble;
    logic                  id_ex_write;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  flush_ex_mem;
    logic                  ex_mem_hold;
    logic                  mem_timeout_err;
    logic [1:0]            state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, mem_access, dmem_ready,
        input  pc_write, if_id_write, id_ex_bubble, id_ex_write, flush_if_id,
               flush_id_ex, flush_ex_mem, ex_mem_hold, mem_timeout_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, mem_access, dmem_ready,
        output pc_write, if_id_write, id_ex_bubble, id_ex_write, flush_if_id,
               flush_id_ex, flush_ex_mem, ex_mem_hold, mem_timeout_err, state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard/stall/flush sequencer for the 5-stage core with a data-memory watchdog.
// Optional macro HAZ_PERF_CNT_EN adds stall_cycles / flush_count counters.
module hazard_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hif
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
`endif
);
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
        $error("hazard_control_unit: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic [REG_ADDR_W-1:0] src_reg [2];
    logic [1:0]            src_used;
    logic [1:0]            src_match;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  load_use;
    logic                  hold_cond;

    assign src_reg[0]  = hif.id_rs1;
    assign src_reg[1]  = hif.id_rs2;
    assign src_used[0] = hif.id_uses_rs1;
    assign src_used[1] = hif.id_uses_rs2;
    assign ex_rd       = hif.ex_rd;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
        end
    endgenerate

    // x0 is hard-wired zero, so a load into it can never be a true dependency.
    assign load_use  = hif.ex_mem_read && (ex_rd != '0) && (|src_match);
    assign hold_cond = !hif.dmem_ready &&
                       ((state_q == ST_MEM_WAIT) || ((state_q == ST_RUN) && hif.mem_access));

    logic pc_write_c, if_id_write_c, id_ex_write_c, id_ex_bubble_c, flush_c, hold_c;

    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_write_c  = 1'b1;
        id_ex_bubble_c = 1'b0;
        flush_c        = 1'b0;
        hold_c         = 1'b0;
        // Reset forces the run defaults regardless of what the pipeline presents.
        if (rst) begin
            if (state_q == ST_ERROR || hold_cond) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_write_c = 1'b0;
                hold_c        = 1'b1;
            end else if (hif.mem_branch_taken) begin
                flush_c = 1'b1;
            end else if (load_use) begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_RUN: begin
                if (hif.mem_access && !hif.dmem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hif.dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hif.pc_write        = pc_write_c;
    assign hif.if_id_write     = if_id_write_c;
    assign hif.id_ex_write     = id_ex_write_c;
    assign hif.id_ex_bubble    = id_ex_bubble_c;
    assign hif.flush_if_id     = flush_c;
    assign hif.flush_id_ex     = flush_c;
    assign hif.flush_ex_mem    = flush_c;
    assign hif.ex_mem_hold     = hold_c;
    assign hif.mem_timeout_err = err_q;
    assign hif.state           = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Both counters saturate so long runs never wrap back to small values.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write_c && state_q != ST_ERROR && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (flush_c && flush_count_q != '1)
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized
// traffic against a behavioural model of the stall/flush/watchdog rules.
module tb_hazard_control_unit;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    // Vector order: pc, ifid, bubble, idex, fl_if, fl_id, fl_ex, hold, err, state[1:0]
    localparam logic [10:0] V_NORM    = 11'b11010000000;
    localparam logic [10:0] V_LOADUSE = 11'b00110000000;
    localparam logic [10:0] V_BRANCH  = 11'b11011110000;
    localparam logic [10:0] V_HOLD0   = 11'b00000001000;
    localparam logic [10:0] V_HOLD1   = 11'b00000001001;
    localparam logic [10:0] V_REL1    = 11'b11010000001;
    localparam logic [10:0] V_BRREL1  = 11'b11011110001;
    localparam logic [10:0] V_ERROR   = 11'b00000001110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_ADDR_W(5)) hif ();

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    hazard_control_unit #(
        .REG_ADDR_W (5),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    logic [10:0] act_vec;
    assign act_vec = {hif.pc_write, hif.if_id_write, hif.id_ex_bubble, hif.id_ex_write,
                      hif.flush_if_id, hif.flush_id_ex, hif.flush_ex_mem, hif.ex_mem_hold,
                      hif.mem_timeout_err, hif.state};

    int checks = 0;
    int errors = 0;

    // Model: consecutive not-ready cycles of the current access, plus trapped flag.
    bit     m_err;
    bit     m_in_wait;
    int     m_stalls;
    longint m_stall_cnt;
    longint m_flush_cnt;

    function automatic logic [10:0] exp_vec();
        logic       pc = 1'b1, ifid = 1'b1, bub = 1'b0, idex = 1'b1, fl = 1'b0, hold = 1'b0;
        logic [1:0] st;
        bit         stalled, hz;
        if (!rst) return V_NORM;
        st      = m_err ? 2'd2 : (m_in_wait ? 2'd1 : 2'd0);
        stalled = !hif.dmem_ready && (m_in_wait || hif.mem_access);
        hz      = hif.ex_mem_read && hif.ex_rd != 0 &&
                  ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
                   (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
        if (m_err || stalled) begin
            pc = 0; ifid = 0; idex = 0; hold = 1;
        end else if (hif.mem_branch_taken) begin
            fl = 1;
        end else if (hz) begin
            pc = 0; ifid = 0; bub = 1;
        end
        return {pc, ifid, bub, idex, fl, fl, fl, hold, m_err, st};
    endfunction

    task automatic model_reset();
        m_err = 0; m_in_wait = 0; m_stalls = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic model_clock();
        logic [10:0] e;
        bit          stalled;
        if (!rst) begin
            model_reset();
            return;
        end
        e = exp_vec();
        if (!m_err && !e[10] && m_stall_cnt < (64'd1 << CNT_W) - 1) m_stall_cnt++;
        if (e[4] && m_flush_cnt < (64'd1 << CNT_W) - 1) m_flush_cnt++;
        if (!m_err) begin
            stalled = !hif.dmem_ready && (m_in_wait || hif.mem_access);
            if (stalled) begin
                m_stalls++;
                if (m_stalls >= MEM_TIMEOUT) begin
                    m_err = 1; m_in_wait = 0;
                end else begin
                    m_in_wait = 1;
                end
            end else begin
                m_in_wait = 0; m_stalls = 0;
            end
        end
    endtask

    task automatic set_idle();
        hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_uses_rs1 = 0; hif.id_uses_rs2 = 0;
        hif.ex_rd = 0; hif.ex_mem_read = 0; hif.mem_branch_taken = 0;
        hif.mem_access = 0; hif.dmem_ready = 1;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 0;
        model_reset();
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        model_reset();
        hif.ex_mem_read = 1; hif.ex_rd = 3; hif.id_rs1 = 3; hif.id_uses_rs1 = 1;
        hif.mem_branch_taken = 1; hif.mem_access = 1; hif.dmem_ready = 0;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL reset_outputs act=%b exp=%b", act_vec, V_NORM);
        end
        @(posedge clk); #1;
        set_idle();
        rst = 1;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL reset_idle act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        apply_reset();
        hif.ex_mem_read = 1; hif.ex_rd = 5; hif.id_rs2 = 5; hif.id_uses_rs2 = 1;
        hif.id_rs1 = 7; hif.id_uses_rs1 = 1;
        settle();
        checks++;
        if (act_vec !== V_LOADUSE) begin
            errors++; $display("FAIL load_use_stall act=%b exp=%b", act_vec, V_LOADUSE);
        end
        advance();
        hif.ex_mem_read = 0;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL load_use_bubble_clears act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        hif.ex_mem_read = 1; hif.ex_rd = 0; hif.id_rs2 = 0;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL load_use_x0 act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        hif.ex_rd = 9; hif.id_rs1 = 9; hif.id_uses_rs1 = 0; hif.id_rs2 = 4;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL load_use_unused_src act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        hif.id_uses_rs1 = 1;
        settle();
        checks++;
        if (act_vec !== V_LOADUSE) begin
            errors++; $display("FAIL load_use_rs1 act=%b exp=%b", act_vec, V_LOADUSE);
        end
        advance();
        set_idle();
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        apply_reset();
        hif.ex_mem_read = 1; hif.ex_rd = 5; hif.id_rs2 = 5; hif.id_uses_rs2 = 1;
        hif.mem_branch_taken = 1;
        settle();
        checks++;
        if (act_vec !== V_BRANCH) begin
            errors++; $display("FAIL branch_over_load_use act=%b exp=%b", act_vec, V_BRANCH);
        end
        advance();
        hif.mem_access = 1; hif.dmem_ready = 0;
        settle();
        checks++;
        if (act_vec !== V_HOLD0) begin
            errors++; $display("FAIL hold_over_branch act=%b exp=%b", act_vec, V_HOLD0);
        end
        advance();
        hif.dmem_ready = 1;
        settle();
        checks++;
        if (act_vec !== V_BRREL1) begin
            errors++; $display("FAIL branch_on_release act=%b exp=%b", act_vec, V_BRREL1);
        end
        advance();
        set_idle();
        $display("test_branch done");
    endtask

    task automatic test_mem_wait();
        logic [10:0] exp;
        apply_reset();
        hif.mem_access = 1; hif.dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            exp = (i == 0) ? V_HOLD0 : V_HOLD1;
            settle();
            checks++;
            if (act_vec !== exp) begin
                errors++; $display("FAIL mem_wait_cycle%0d act=%b exp=%b", i, act_vec, exp);
            end
            advance();
        end
        hif.dmem_ready = 1;
        settle();
        checks++;
        if (act_vec !== V_REL1) begin
            errors++; $display("FAIL mem_wait_release act=%b exp=%b", act_vec, V_REL1);
        end
        advance();
        hif.mem_access = 0;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL mem_wait_back_to_run act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        $display("test_mem_wait done");
    endtask

    task automatic test_timeout();
        logic [10:0] exp;
        apply_reset();
        hif.mem_access = 1; hif.dmem_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            exp = (i == 0) ? V_HOLD0 : V_HOLD1;
            settle();
            checks++;
            if (act_vec !== exp) begin
                errors++; $display("FAIL timeout_stall%0d act=%b exp=%b", i, act_vec, exp);
            end
            advance();
        end
        hif.mem_access = 0; hif.dmem_ready = 1; hif.mem_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (act_vec !== V_ERROR) begin
                errors++; $display("FAIL timeout_sticky%0d act=%b exp=%b", i, act_vec, V_ERROR);
            end
            advance();
        end
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL timeout_cleared_by_reset act=%b exp=%b", act_vec, V_NORM);
        end
        set_idle();
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        hif.mem_access = 1; hif.dmem_ready = 0;
        advance();
        advance();
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL reset_mid_wait act=%b exp=%b", act_vec, V_NORM);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            errors++; $display("FAIL reset_mid_wait_counters act=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
`endif
        set_idle();
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        settle();
        checks++;
        if (act_vec !== V_NORM) begin
            errors++; $display("FAIL after_reset_mid_wait act=%b exp=%b", act_vec, V_NORM);
        end
        advance();
        $display("test_reset_mid_wait done");
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            hif.ex_mem_read = 1; hif.ex_rd = 6; hif.id_rs1 = 6; hif.id_uses_rs1 = 1;
            advance();
            set_idle();
            advance();
        end
        hif.mem_branch_taken = 1;
        advance();
        set_idle();
        settle();
        checks++;
        if (stall_cycles !== CNT_W'(2) || flush_count !== CNT_W'(1)) begin
            errors++; $display("FAIL perf_counts act=%0d/%0d exp=2/1", stall_cycles, flush_count);
        end
        advance();
        $display("test_perf_counters done");
    endtask
`endif

    task automatic test_random();
        logic [10:0] exp;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 2) begin
                rst = 0;
                model_reset();
            end else begin
                rst = 1;
            end
            hif.id_rs1           = 5'($urandom_range(3));
            hif.id_rs2           = 5'($urandom_range(3));
            hif.ex_rd            = 5'($urandom_range(3));
            hif.id_uses_rs1      = 1'($urandom_range(1));
            hif.id_uses_rs2      = 1'($urandom_range(1));
            hif.ex_mem_read      = 1'($urandom_range(1));
            hif.mem_branch_taken = ($urandom_range(99) < 15);
            hif.mem_access       = ($urandom_range(99) < 40);
            hif.dmem_ready       = ($urandom_range(99) < 55);
            settle();
            exp = exp_vec();
            checks++;
            if (act_vec !== exp) begin
                errors++; $display("FAIL random_cycle%0d act=%b exp=%b", n, act_vec, exp);
            end
`ifdef HAZ_PERF_CNT_EN
            checks++;
            if (stall_cycles !== CNT_W'(m_stall_cnt) || flush_count !== CNT_W'(m_flush_cnt)) begin
                errors++;
                $display("FAIL random_counters%0d act=%0d/%0d exp=%0d/%0d",
                         n, stall_cycles, flush_count, m_stall_cnt, m_flush_cnt);
            end
`endif
            advance();
        end
        rst = 1;
        set_idle();
        $display("test_random done");
    endtask

    initial begin
        set_idle();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
`ifdef HAZ_PERF_CNT_EN
        test_perf_counters();
`endif
        apply_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
